// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, controller state encoding, operand/result bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    localparam int SHIFT_TIMEOUT_DEFAULT = 31;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_EXEC        = 3'd1,
        ST_SHIFT_START = 3'd2,
        ST_SHIFT_WAIT  = 3'd3,
        ST_RESP        = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0]        mode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              zero;
        logic              err;
    } rsp_t;

    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == ALU_SHL) || (mode == ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation at a time and returns its result with zero/err flags.
// Latency: non-shift result valid two edges after request; shifts wait for ALU done or SHIFT_TIMEOUT.
// Backpressure: req_ready only in IDLE (nothing queued); result held in RESP until rsp_ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int SHIFT_TIMEOUT = SHIFT_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_mode,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_mode,
    output logic        alu_start_shift,
    input  logic [15:0] alu_answer,
    input  logic        alu_zero,
    input  logic        alu_done_shift,
    output logic [15:0] ops_done
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(SHIFT_TIMEOUT);

    state_e      state_q, state_d;
    op_t         op_q;
    rsp_t        rsp_q, rsp_d;
    logic [7:0]  cnt_q, cnt_nxt;
    logic [15:0] ops_done_q;
    logic        op_load, rsp_load, cnt_clr, cnt_inc, ops_inc;

    assign cnt_nxt = cnt_q + 8'd1;

    // Next-state and datapath enables; alu_done_shift is only looked at in SHIFT_WAIT.
    always_comb begin
        state_d   = state_q;
        op_load   = 1'b0;
        rsp_load  = 1'b0;
        rsp_d     = '0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        ops_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_load = 1'b1;
                    state_d = is_shift(req_mode) ? ST_SHIFT_START : ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_load   = 1'b1;
                rsp_d.data = alu_answer;
                rsp_d.zero = alu_zero;
                state_d    = ST_RESP;
            end
            ST_SHIFT_START: begin
                cnt_clr = 1'b1;
                state_d = ST_SHIFT_WAIT;
            end
            ST_SHIFT_WAIT: begin
                cnt_inc = 1'b1;
                // A done arriving on the timeout cycle still delivers the real result.
                if (alu_done_shift) begin
                    rsp_load   = 1'b1;
                    rsp_d.data = alu_answer;
                    rsp_d.zero = alu_zero;
                    state_d    = ST_RESP;
                end else if (cnt_nxt >= TIMEOUT_CNT) begin
                    rsp_load  = 1'b1;
                    rsp_d.err = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    ops_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Operand registers: the only source of alu_* so they stay put for the whole op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= '0;
        end else if (op_load) begin
            op_q.mode <= req_mode;
            op_q.a    <= req_a;
            op_q.b    <= req_b;
        end
    end

    // Captured result, held unchanged through RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      rsp_q <= '0;
        else if (rsp_load) rsp_q <= rsp_d;
    end

    // Shift wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     cnt_q <= '0;
        else if (cnt_clr) cnt_q <= '0;
        else if (cnt_inc) cnt_q <= cnt_nxt;
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     ops_done_q <= '0;
        else if (ops_inc) ops_done_q <= ops_done_q + 16'd1;
    end

    // reset_n gates ready so it reads 0 while reset is held.
    assign req_ready       = (state_q == ST_IDLE) && reset_n;
    assign rsp_valid       = (state_q == ST_RESP);
    assign rsp_data        = rsp_q.data;
    assign rsp_zero        = rsp_q.zero;
    assign rsp_err         = rsp_q.err;
    assign alu_a           = op_q.a;
    assign alu_b           = op_q.b;
    assign alu_mode        = op_q.mode;
    assign alu_start_shift = (state_q == ST_SHIFT_START);
    assign ops_done        = ops_done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU beside the DUT, vector table, directed corners, random ops.
// Latency: checks result timing against request/done edges.
// Backpressure: exercises rsp_ready stalls with a pending request.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int T = 31;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_mode;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_err;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_mode;
    logic        alu_start_shift;
    logic [15:0] alu_answer;
    logic        alu_zero, alu_done_shift;
    logic [15:0] ops_done;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned start_cnt = 0;
    int unsigned last_start_cyc = 0;
    int unsigned done_cyc = 0;
    int done_delay = 0;
    bit stale_done = 1'b0;
    int exp_ops = 0;

    alu_issue_ctrl #(.SHIFT_TIMEOUT(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_start_shift(alu_start_shift), .alu_answer(alu_answer),
        .alu_zero(alu_zero), .alu_done_shift(alu_done_shift), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (alu_start_shift === 1'b1) begin
            start_cnt      <= start_cnt + 1;
            last_start_cyc <= cyc;
        end
    end

    // Reference ALU arithmetic straight from the op-code table.
    function automatic logic [15:0] ref_alu(input logic [2:0] mode, input logic [15:0] a, input logic [15:0] b);
        logic [3:0] sh;
        sh = b[3:0];
        case (mode)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            ALU_SHL: return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    always_comb begin
        alu_answer = ref_alu(alu_mode, alu_a, alu_b);
        alu_zero   = (alu_answer == 16'd0);
    end

    // Shift unit model: done pulse done_delay cycles after start (0 = never), optional stale done in SHIFT_START.
    initial begin
        alu_done_shift = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (alu_start_shift === 1'b1) begin
                if (stale_done) alu_done_shift = 1'b1;
                if (done_delay == 0) begin
                    @(posedge clk); #1;
                    alu_done_shift = 1'b0;
                end else begin
                    for (int k = 1; k <= done_delay; k++) begin
                        @(posedge clk); #1;
                        alu_done_shift = (k == done_delay);
                        if (k == done_delay) done_cyc = cyc;
                    end
                    @(posedge clk); #1;
                    alu_done_shift = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (req_ready === 1'b1);
        end
        if (!ok) check({tag, " ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (rsp_valid === 1'b1);
        end
        if (!ok) check({tag, " rsp_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_ops++;
        check({tag, " ops_done"}, 32'(ops_done), 32'(exp_ops[15:0]));
        check({tag, " post_hs"}, 32'({rsp_valid, req_ready}), 32'(2'b01));
    endtask

    task automatic run_op(input string tag, input logic [2:0] mode, input logic [15:0] a, input logic [15:0] b,
                          input int delay, input bit stale, input int stall,
                          input logic [15:0] exp_data, input logic exp_zero, input logic exp_err);
        bit ok;
        int unsigned t0, tr, s0, lat_exp;
        done_delay = delay;
        stale_done = stale;
        s0 = start_cnt;
        wait_ready(tag, ok);
        if (!ok) return;
        req_valid = 1'b1; req_mode = mode; req_a = a; req_b = b;
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_mode = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
        wait_rsp(tag, ok);
        if (!ok) return;
        tr = cyc;
        if (!is_shift(mode))                lat_exp = t0 + 2;
        else if (delay >= 1 && delay <= T)  lat_exp = done_cyc + 1;
        else                                lat_exp = last_start_cyc + T + 1;
        check({tag, " latency"}, tr, lat_exp);
        check({tag, " start_pulses"}, start_cnt - s0, is_shift(mode) ? 32'd1 : 32'd0);
        check({tag, " data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, " zero_err"}, 32'({rsp_zero, rsp_err}), 32'({exp_zero, exp_err}));
        check({tag, " alu_ops"}, 32'({alu_mode, alu_a, alu_b} >> 16), 32'({mode, a, b} >> 16));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " stall_hold"}, 32'({rsp_valid, req_ready, rsp_err, rsp_data}),
                  32'({1'b1, 1'b0, exp_err, exp_data}));
        end
        handshake(tag);
    endtask

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] a;
        logic [15:0] b;
        int          delay;
        bit          stale;
        logic [15:0] exp_data;
        logic        exp_zero;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit ok;
        logic [2:0]  m;
        logic [15:0] a, b, ed;
        int d, r;
        bit st, ee;

        vecs[0]  = '{ALU_ADD, 16'h0003, 16'h0004, 0,  1'b0, 16'h0007, 1'b0, 1'b0};
        vecs[1]  = '{ALU_SUB, 16'h1234, 16'h1234, 0,  1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{ALU_AND, 16'hF0F0, 16'hFF00, 0,  1'b0, 16'hF000, 1'b0, 1'b0};
        vecs[3]  = '{ALU_OR,  16'h00F0, 16'h0F00, 0,  1'b0, 16'h0FF0, 1'b0, 1'b0};
        vecs[4]  = '{ALU_XOR, 16'hAAAA, 16'hAAAA, 0,  1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{ALU_SLT, 16'hFFFF, 16'h0001, 0,  1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[6]  = '{ALU_SHL, 16'h0001, 16'h0004, 4,  1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[7]  = '{ALU_SHR, 16'h8000, 16'h000F, 2,  1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{ALU_SHL, 16'h1234, 16'h0013, T,  1'b0, 16'h91A0, 1'b0, 1'b0};
        vecs[9]  = '{ALU_SHR, 16'h1234, 16'h0004, 0,  1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[10] = '{ALU_SHL, 16'hFFFF, 16'h0010, 1,  1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[11] = '{ALU_ADD, 16'hFFFF, 16'h0001, 0,  1'b0, 16'h0000, 1'b1, 1'b0};

        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_mode = '0; req_a = '0; req_b = '0;
        #1;
        check("reset_outputs", 32'({req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_start_shift, alu_mode}), 32'd0);
        check("reset_operands", {alu_a, alu_b}, 32'd0);
        check("reset_ops_done", 32'(ops_done), 32'd0);
        #22 reset_n = 1'b1;
        #1;
        check("ready_after_release", 32'(req_ready), 32'd1);

        // Result stall with a second request pending: nothing accepted until handshake.
        wait_ready("stall", ok);
        req_valid = 1'b1; req_mode = ALU_ADD; req_a = 16'h0100; req_b = 16'h0023;
        @(posedge clk); #1;
        req_mode = ALU_XOR; req_a = 16'h00FF; req_b = 16'h0F0F;
        wait_rsp("stall_op1", ok);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_op1_hold", 32'({rsp_valid, req_ready, rsp_zero, rsp_err, rsp_data}),
                  32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0123}));
            check("stall_op1_alu_a", 32'(alu_a), 32'h0100);
        end
        handshake("stall_op1");
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("stall_op2_latched", 32'({alu_mode, alu_a}), 32'({ALU_XOR, 16'h00FF}));
        wait_rsp("stall_op2", ok);
        check("stall_op2_data", 32'(rsp_data), 32'h0FF0);
        handshake("stall_op2");
        check("stall_ops_done_2", 32'(ops_done), 32'd2);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].delay, vecs[i].stale,
                   (i == 0) ? 2 : 0, vecs[i].exp_data, vecs[i].exp_zero, vecs[i].exp_err);
        end

        // Reset pulsed while waiting on a shift: op abandoned, then normal service resumes.
        done_delay = 0; stale_done = 1'b0;
        wait_ready("rst", ok);
        req_valid = 1'b1; req_mode = ALU_SHR; req_a = 16'hBEEF; req_b = 16'h0003;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_start_shift, alu_mode}), 32'd0);
        check("rst_mid_operands", {alu_a, alu_b}, 32'd0);
        check("rst_mid_ops_done", 32'(ops_done), 32'd0);
        exp_ops = 0;
        @(posedge clk); #3;
        reset_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_response", 32'(rsp_valid), 32'd0);
        end
        run_op("rst_add", ALU_ADD, 16'h0001, 16'h0001, 0, 1'b0, 0, 16'h0002, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            m = 3'($urandom_range(0, 7));
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            r = $urandom_range(0, 9);
            d = (r == 0) ? 0 : ((r == 1) ? T : $urandom_range(1, 6));
            st = 1'($urandom_range(0, 1));
            if (is_shift(m) && d == 0) begin
                ed = 16'h0000; ee = 1'b1;
            end else begin
                ed = ref_alu(m, a, b); ee = 1'b0;
            end
            run_op($sformatf("rnd%0d", n), m, a, b, d, st, $urandom_range(0, 3),
                   ed, (!ee && ed == 16'h0000), ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
